// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte transmit path.
package i2c_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, ACK} tx_state_t;

   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; idles at all-ones so a released line reads high.
module flex_pts_sr #(
   parameter int unsigned NUM_BITS  = 8,
   parameter bit          SHIFT_MSB = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_enable,
   input  logic                shift_enable,
   input  logic [NUM_BITS-1:0] parallel_in,
   output logic                serial_out
);

   logic [NUM_BITS-1:0] sr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '1;
      end else if (load_enable) begin
         sr_q <= parallel_in;
      end else if (shift_enable) begin
         if (SHIFT_MSB) sr_q <= {sr_q[NUM_BITS-2:0], 1'b1};
         else           sr_q <= {1'b1, sr_q[NUM_BITS-1:1]};
      end
   end

   assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/i2c_byte_tx.sv
// I2C byte transmitter: serializes a word onto open-drain SDA during SCL low phases,
// then releases SDA for the acknowledge slot and reports ACK/NACK.
module i2c_byte_tx
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_BITS  = 8,
   parameter bit          SHIFT_MSB = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scl_in,
   input  logic                sda_in,
   input  logic                stop_det,
   input  logic [NUM_BITS-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                sda_drive_low,
   output logic                busy,
   output logic                ack_valid,
   output logic                ack_received
);

   localparam int unsigned         CNT_W    = $clog2(NUM_BITS) + 1;
   localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(NUM_BITS - 1);

   // Index 0 = s1, SYNC_STAGES-1 = s2, SYNC_STAGES = history flop
   logic [SYNC_STAGES:0]   scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-1:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      end
   end

   logic scl_s2, scl_s3, sda_s2;
   logic scl_rise, scl_fall;

   assign scl_s2   = scl_sync_q[SYNC_STAGES-1];
   assign scl_s3   = scl_sync_q[SYNC_STAGES];
   assign sda_s2   = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s2 & ~scl_s3;
   assign scl_fall = ~scl_s2 & scl_s3;

   tx_state_t        state_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic             accept, shift_en, sr_load, serial_bit;
   logic [NUM_BITS-1:0] sr_in;

   assign accept   = (state_q == IDLE) & tx_valid & ~stop_det;
   assign shift_en = (state_q == SHIFT) & scl_fall & (bit_cnt_q != LAST_BIT) & ~stop_det;
   // An abort reloads all-ones so the line stays released afterwards
   assign sr_load  = accept | stop_det;
   assign sr_in    = stop_det ? '1 : tx_data;

   flex_pts_sr #(
      .NUM_BITS  (NUM_BITS),
      .SHIFT_MSB (SHIFT_MSB)
   ) u_sr (
      .clk          (clk),
      .rst          (rst),
      .load_enable  (sr_load),
      .shift_enable (shift_en),
      .parallel_in  (sr_in),
      .serial_out   (serial_bit)
   );

   assign sda_drive_low = (state_q == SHIFT) & ~serial_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         tx_ready     <= 1'b1;
         busy         <= 1'b0;
         ack_valid    <= 1'b0;
         ack_received <= 1'b0;
      end else begin
         ack_valid <= 1'b0;
         if (stop_det) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (tx_valid) begin
                     state_q   <= SHIFT;
                     bit_cnt_q <= '0;
                     tx_ready  <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (scl_fall) begin
                     if (bit_cnt_q == LAST_BIT) state_q   <= ACK;
                     else                       bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
               ACK: begin
                  if (scl_rise) begin
                     ack_received <= ~sda_s2;
                  end else if (scl_fall) begin
                     ack_valid <= 1'b1;
                     state_q   <= IDLE;
                     tx_ready  <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
